// File: rtl/boot_sequencer.sv
// Boot sequencer: holds the CPU in reset while the start-up ROM is copied into
// instruction memory and the data region is zero-filled, then releases the CPU.
module boot_sequencer #(
  parameter int ROM_WORDS   = 12,
  parameter int CLEAR_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reboot,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  input  logic        cpu_dmem_we,
  input  logic [31:0] cpu_dmem_addr,
  input  logic [31:0] cpu_dmem_wdata,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        cpu_rst,
  output logic        done
);

  localparam int CLEAR_WORDS = CLEAR_BYTES / 4;
  localparam int MAX_WORDS   = (ROM_WORDS > CLEAR_WORDS) ? ROM_WORDS : CLEAR_WORDS;
  localparam int IDX_W       = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  localparam logic [IDX_W-1:0] COPY_LAST  = IDX_W'((ROM_WORDS > 0) ? ROM_WORDS - 1 : 0);
  localparam logic [IDX_W-1:0] CLEAR_LAST = IDX_W'((CLEAR_WORDS > 0) ? CLEAR_WORDS - 1 : 0);

  typedef enum logic [1:0] {
    ST_COPY,
    ST_CLEAR,
    ST_RELEASE,
    ST_RUN
  } state_t;

  // Empty phases are skipped so a pass always starts in the first non-empty one.
  localparam state_t START_STATE = (ROM_WORDS > 0)   ? ST_COPY  :
                                   (CLEAR_WORDS > 0) ? ST_CLEAR : ST_RELEASE;
  localparam state_t AFTER_COPY  = (CLEAR_WORDS > 0) ? ST_CLEAR : ST_RELEASE;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      byte_addr;

  assign byte_addr = {{(30 - IDX_W){1'b0}}, idx_q, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= START_STATE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_COPY: begin
        if (idx_q == COPY_LAST) begin
          state_d = AFTER_COPY;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_CLEAR: begin
        if (idx_q == CLEAR_LAST) begin
          state_d = ST_RELEASE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_RELEASE: state_d = ST_RUN;
      ST_RUN: begin
        if (reboot) begin
          state_d = START_STATE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = START_STATE;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs depend only on registered state, so rst/reboot never reach them combinationally.
  always_comb begin
    rom_addr   = '0;
    imem_we    = 1'b0;
    imem_addr  = '0;
    imem_wdata = '0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    cpu_rst    = 1'b1;
    done       = 1'b0;
    case (state_q)
      ST_COPY: begin
        rom_addr   = byte_addr;
        imem_we    = 1'b1;
        imem_addr  = byte_addr;
        imem_wdata = rom_data;
      end
      ST_CLEAR: begin
        dmem_we   = 1'b1;
        dmem_addr = byte_addr;
      end
      ST_RUN: begin
        cpu_rst    = 1'b0;
        done       = 1'b1;
        dmem_we    = cpu_dmem_we;
        dmem_addr  = cpu_dmem_addr;
        dmem_wdata = cpu_dmem_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_boot_sequencer.sv
// Testbench for boot_sequencer: randomized directed sequence checked every cycle
// against a cycle-count model of the boot phases, for default and empty-phase builds.
module tb_boot_sequencer;

  localparam int RW_A = 12;
  localparam int CW_A = 256;
  localparam int RW_B = 0;
  localparam int CW_B = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        reboot;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;

  logic [31:0] rom_mem [RW_A];
  logic [31:0] rom_data_b;

  logic [31:0] rom_addr_a, imem_addr_a, imem_wdata_a, dmem_addr_a, dmem_wdata_a;
  logic        imem_we_a, dmem_we_a, cpu_rst_a, done_a;
  logic [31:0] rom_data_a;
  logic [31:0] rom_addr_b, imem_addr_b, imem_wdata_b, dmem_addr_b, dmem_wdata_b;
  logic        imem_we_b, dmem_we_b, cpu_rst_b, done_b;

  int total = 0;
  int bad   = 0;

  int  t_a = 0;
  int  t_b = 0;
  int  cyc_idx = 0;
  int  imem_cnt = 0;
  int  dmem_cnt = 0;
  bit  model_valid = 1'b0;
  logic prev_done_a = 1'b0;

  always #5 clk = ~clk;

  assign rom_data_a = (rom_addr_a < 32'd48) ? rom_mem[rom_addr_a[5:2]] : 32'h0;

  boot_sequencer #(.ROM_WORDS(RW_A), .CLEAR_BYTES(CW_A * 4)) dut_a (
    .clk(clk), .rst(rst), .reboot(reboot),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .imem_we(imem_we_a), .imem_addr(imem_addr_a), .imem_wdata(imem_wdata_a),
    .cpu_dmem_we(cpu_we), .cpu_dmem_addr(cpu_addr), .cpu_dmem_wdata(cpu_wdata),
    .dmem_we(dmem_we_a), .dmem_addr(dmem_addr_a), .dmem_wdata(dmem_wdata_a),
    .cpu_rst(cpu_rst_a), .done(done_a)
  );

  boot_sequencer #(.ROM_WORDS(RW_B), .CLEAR_BYTES(CW_B * 4)) dut_b (
    .clk(clk), .rst(rst), .reboot(reboot),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .imem_we(imem_we_b), .imem_addr(imem_addr_b), .imem_wdata(imem_wdata_b),
    .cpu_dmem_we(cpu_we), .cpu_dmem_addr(cpu_addr), .cpu_dmem_wdata(cpu_wdata),
    .dmem_we(dmem_we_b), .dmem_addr(dmem_addr_b), .dmem_wdata(dmem_wdata_b),
    .cpu_rst(cpu_rst_b), .done(done_b)
  );

  // Expected outputs from "cycles into the current pass": copy words, then clear
  // words, then one release cycle, then run.
  function automatic logic [163:0] exp_vec(input int t, input int rw, input int cw,
                                           input logic [31:0] rom_word);
    logic [31:0] ra, ia, iw, da, dw;
    logic        iwe, dwe, crst, dn;
    ra = 0; ia = 0; iw = 0; da = 0; dw = 0;
    iwe = 0; dwe = 0; crst = 1; dn = 0;
    if (t < rw) begin
      ra = t * 4; iwe = 1; ia = t * 4; iw = rom_word;
    end else if (t < rw + cw) begin
      dwe = 1; da = (t - rw) * 4;
    end else if (t > rw + cw) begin
      crst = 0; dn = 1; dwe = cpu_we; da = cpu_addr; dw = cpu_wdata;
    end
    return {ra, iwe, ia, iw, dwe, da, dw, crst, dn};
  endfunction

  function automatic int next_t(input int t, input int rw, input int cw,
                                input logic r, input logic rb);
    if (r) return 0;
    if (t > rw + cw) return rb ? 0 : t;
    return t + 1;
  endfunction

  task automatic checkOutput();
    logic [163:0] obs_a, obs_b, want_a, want_b;
    logic [31:0]  word;
    if (!model_valid) return;
    word   = (t_a < RW_A) ? rom_mem[t_a] : 32'h0;
    want_a = exp_vec(t_a, RW_A, CW_A, word);
    want_b = exp_vec(t_b, RW_B, CW_B, 32'h0);
    obs_a  = {rom_addr_a, imem_we_a, imem_addr_a, imem_wdata_a,
              dmem_we_a, dmem_addr_a, dmem_wdata_a, cpu_rst_a, done_a};
    obs_b  = {rom_addr_b, imem_we_b, imem_addr_b, imem_wdata_b,
              dmem_we_b, dmem_addr_b, dmem_wdata_b, cpu_rst_b, done_b};
    total++;
    assert (obs_a === want_a) else begin
      bad++;
      $error("[TB] FAIL outputs_default t=%0d observed=%h expected=%h", t_a, obs_a, want_a);
    end
    total++;
    assert (obs_b === want_b) else begin
      bad++;
      $error("[TB] FAIL outputs_empty t=%0d observed=%h expected=%h", t_b, obs_b, want_b);
    end
    if (t_a == 0) begin
      imem_cnt = 0;
      dmem_cnt = 0;
    end
    if (imem_we_a === 1'b1) imem_cnt++;
    if (dmem_we_a === 1'b1 && t_a <= RW_A + CW_A) dmem_cnt++;
    if (t_a == RW_A + CW_A) begin
      total++;
      assert (imem_cnt === RW_A) else begin
        bad++;
        $error("[TB] FAIL imem_write_count observed=%0d expected=%0d", imem_cnt, RW_A);
      end
      total++;
      assert (dmem_cnt === CW_A) else begin
        bad++;
        $error("[TB] FAIL dmem_write_count observed=%0d expected=%0d", dmem_cnt, CW_A);
      end
    end
    if (done_a === 1'b1 && prev_done_a !== 1'b1) begin
      total++;
      assert (cyc_idx === RW_A + CW_A + 1) else begin
        bad++;
        $error("[TB] FAIL run_start_cycle observed=%0d expected=%0d", cyc_idx, RW_A + CW_A + 1);
      end
    end
    prev_done_a = done_a;
  endtask

  task automatic applyStimulus(input logic r, input logic rb, input logic we,
                               input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    rst        = r;
    reboot     = rb;
    cpu_we     = we;
    cpu_addr   = addr;
    cpu_wdata  = data;
    rom_data_b = $urandom;
    #1;
    checkOutput();
    @(posedge clk);
    t_a         = next_t(t_a, RW_A, CW_A, r, rb);
    t_b         = next_t(t_b, RW_B, CW_B, r, rb);
    cyc_idx     = (t_a == 0) ? 0 : cyc_idx + 1;
    if (r) model_valid = 1'b1;
  endtask

  // Boot-phase step: CPU keeps trying to write, reboot toggles randomly and must be ignored.
  task automatic bootSteps(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'($urandom_range(0, 1)) & (t_a <= RW_A + CW_A), 1'b1, $urandom, $urandom);
  endtask

  task automatic runSteps(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
  endtask

  initial begin
    rst = 1'b1; reboot = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; rom_data_b = '0;
    rom_mem[0] = 32'h40000113;
    for (int i = 1; i < RW_A; i++) rom_mem[i] = $urandom;

    applyStimulus(1'b1, 1'b0, 1'b1, $urandom, $urandom);
    applyStimulus(1'b1, 1'b0, 1'b1, $urandom, $urandom);
    bootSteps(RW_A + CW_A + 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h10, 32'hdeadbeef);
    runSteps(20);

    $display("[TB] reboot from run");
    applyStimulus(1'b0, 1'b1, 1'b1, $urandom, $urandom);
    bootSteps(150);
    applyStimulus(1'b0, 1'b1, 1'b1, $urandom, $urandom);
    bootSteps(RW_A + CW_A + 1 - 151);
    runSteps(10);

    $display("[TB] reset mid-clear");
    applyStimulus(1'b0, 1'b1, 1'b0, $urandom, $urandom);
    bootSteps(100);
    applyStimulus(1'b1, 1'b0, 1'b1, $urandom, $urandom);
    applyStimulus(1'b1, 1'b0, 1'b1, $urandom, $urandom);
    bootSteps(RW_A + CW_A + 1);
    runSteps(10);

    $display("[TB] reset and reboot together");
    applyStimulus(1'b1, 1'b1, 1'b1, $urandom, $urandom);
    bootSteps(RW_A + CW_A + 1);
    runSteps(15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
